// File: rtl/stream_router_if.sv
// Bundle of the stream_router's reader-side, key-side and data-side signals.
// Ports: in_* from the byte reader; key_* to key storage; data_*/fifo_count to the
//        encryption block; overflow/drop_nokey/err_clr for error reporting.
// slave modport is the router's view; master modport is the surrounding logic's view.
interface stream_router_if #(
   parameter int DATA_W     = 8,
   parameter int KEY_WORDS  = 16,
   parameter int FIFO_DEPTH = 4
);
   localparam int IDX_W = $clog2(KEY_WORDS);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [DATA_W-1:0] in_word;
   logic              in_is_key;
   logic              in_pulse;

   logic [DATA_W-1:0] key_word;
   logic [IDX_W-1:0]  key_idx;
   logic              key_pulse;
   logic              key_done;
   logic              key_ready;

   logic [DATA_W-1:0] data_word;
   logic              data_valid;
   logic              data_ready;
   logic [CNT_W-1:0]  fifo_count;

   logic              overflow;
   logic              drop_nokey;
   logic              err_clr;

   modport slave (
      input  in_word, in_is_key, in_pulse, data_ready, err_clr,
      output key_word, key_idx, key_pulse, key_done, key_ready,
             data_word, data_valid, fifo_count, overflow, drop_nokey
   );

   modport master (
      output in_word, in_is_key, in_pulse, data_ready, err_clr,
      input  key_word, key_idx, key_pulse, key_done, key_ready,
             data_word, data_valid, fifo_count, overflow, drop_nokey
   );
endinterface

// File: rtl/stream_router.sv
// Purpose: steers pulsed reader words to the key path (slot index + completion) or a data FIFO.
// Latency: key words appear one cycle after in_pulse; data is visible the cycle after the push.
// Backpressure: data_ready stalls the FIFO head; a full FIFO without a same-cycle pop drops the word.
// Ports: clk/rst (sync, active-high) plus bus (slave modport): in_word/in_is_key/in_pulse in;
//        key_word/key_idx/key_pulse/key_done/key_ready out; data_word/data_valid out, data_ready in;
//        fifo_count, sticky overflow/drop_nokey out, err_clr in.
module stream_router #(
   parameter int DATA_W     = 8,
   parameter int KEY_WORDS  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   stream_router_if.slave   bus
);
   localparam int IDX_W = $clog2(KEY_WORDS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] ST_NOKEY   = 2'd0;
   localparam logic [1:0] ST_LOADING = 2'd1;
   localparam logic [1:0] ST_READY   = 2'd2;

   logic [1:0]        state;
   logic [IDX_W-1:0]  key_cnt;
   logic [IDX_W-1:0]  slot;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic key_hit;
   logic data_hit;
   logic have_key;
   logic rekey;
   logic last_word;
   logic fifo_full;
   logic data_valid;
   logic pop;
   logic push;

   assign key_hit   = bus.in_pulse &  bus.in_is_key;
   assign data_hit  = bus.in_pulse & ~bus.in_is_key;
   assign have_key  = (state == ST_READY);
   assign rekey     = key_hit & have_key;
   // The counter is already 0 in READY, but force it so a rekey always starts at slot 0.
   assign slot      = rekey ? '0 : key_cnt;
   assign last_word = (slot == IDX_W'(KEY_WORDS - 1));

   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign data_valid = (count != '0);
   assign pop        = data_valid & bus.data_ready;
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign push       = data_hit & have_key & (~fifo_full | pop);

   // ---------------- key path ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_NOKEY;
         key_cnt       <= '0;
         bus.key_word  <= '0;
         bus.key_idx   <= '0;
         bus.key_pulse <= 1'b0;
         bus.key_done  <= 1'b0;
      end else begin
         bus.key_pulse <= key_hit;
         bus.key_done  <= key_hit & last_word;
         if (key_hit) begin
            bus.key_word <= bus.in_word;
            bus.key_idx  <= slot;
            if (last_word) begin
               key_cnt <= '0;
               state   <= ST_READY;
            end else begin
               key_cnt <= slot + 1'b1;
               state   <= ST_LOADING;
            end
         end
      end
   end

   assign bus.key_ready = have_key;

   // ---------------- data FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (rekey) begin
         // Data queued under the old key must not be encrypted with the new one.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.data_word  = data_valid ? mem[rd_ptr] : '0;
   assign bus.data_valid = data_valid;
   assign bus.fifo_count = count;

   // ---------------- sticky error flags ----------------
   // err_clr wins over a same-cycle set event.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.overflow   <= 1'b0;
         bus.drop_nokey <= 1'b0;
      end else begin
         if (bus.err_clr) begin
            bus.overflow <= 1'b0;
         end else if (data_hit & have_key & fifo_full & ~pop) begin
            bus.overflow <= 1'b1;
         end

         if (bus.err_clr) begin
            bus.drop_nokey <= 1'b0;
         end else if (data_hit & ~have_key) begin
            bus.drop_nokey <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_stream_router.sv
module tb_stream_router;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   stream_router_if #(.DATA_W(8), .KEY_WORDS(16), .FIFO_DEPTH(4)) bus ();

   stream_router #(.DATA_W(8), .KEY_WORDS(16), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0] w;
      logic [3:0] idx;
      logic       done;
      logic       rdy;
   } key_exp_t;

   key_exp_t   key_q[$];
   logic [7:0] data_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_key(input logic [7:0] w, input logic [3:0] idx, input logic done);
      key_exp_t e;
      bus.in_pulse  = 1'b1;
      bus.in_is_key = 1'b1;
      bus.in_word   = w;
      e.w = w; e.idx = idx; e.done = done; e.rdy = done;
      key_q.push_back(e);
      tick();
      bus.in_pulse  = 1'b0;
   endtask

   task automatic drive_data(input logic [7:0] w);
      bus.in_pulse  = 1'b1;
      bus.in_is_key = 1'b0;
      bus.in_word   = w;
      tick();
      bus.in_pulse  = 1'b0;
   endtask

   // Monitor: compare every key strobe and every data handshake against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.key_pulse) begin
            if (key_q.size() == 0) begin
               check("unexpected_key_pulse", 1, 0);
            end else begin
               key_exp_t e;
               e = key_q.pop_front();
               check("key_word",  bus.key_word,  e.w);
               check("key_idx",   bus.key_idx,   e.idx);
               check("key_done",  bus.key_done,  e.done);
               check("key_ready", bus.key_ready, e.rdy);
            end
         end
         if (bus.data_valid && bus.data_ready) begin
            if (data_q.size() == 0) begin
               check("unexpected_data", 1, 0);
            end else begin
               check("data_word", bus.data_word, data_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.in_word    = '0;
      bus.in_is_key  = 1'b0;
      bus.in_pulse   = 1'b0;
      bus.data_ready = 1'b0;
      bus.err_clr    = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_key_pulse",  bus.key_pulse,  0);
      check("rst_key_done",   bus.key_done,   0);
      check("rst_key_ready",  bus.key_ready,  0);
      check("rst_key_idx",    bus.key_idx,    0);
      check("rst_key_word",   bus.key_word,   0);
      check("rst_data_valid", bus.data_valid, 0);
      check("rst_data_word",  bus.data_word,  0);
      check("rst_fifo_count", bus.fifo_count, 0);
      check("rst_overflow",   bus.overflow,   0);
      check("rst_drop_nokey", bus.drop_nokey, 0);

      // Data without a key is dropped
      drive_data(8'hA5);
      check("nokey_count", bus.fifo_count, 0);
      check("nokey_valid", bus.data_valid, 0);
      check("nokey_drop",  bus.drop_nokey, 1);
      // err_clr together with a new drop: clear wins
      bus.err_clr = 1'b1;
      drive_data(8'hA6);
      check("clr_priority", bus.drop_nokey, 0);
      // set event the cycle after err_clr is recorded
      bus.err_clr = 1'b0;
      drive_data(8'hA7);
      check("set_after_clr", bus.drop_nokey, 1);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      check("drop_cleared", bus.drop_nokey, 0);

      // Full key load: 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         drive_key(8'(i), 4'(i), i == 15);
         if (i < 15) check("ready_during_load", bus.key_ready, 0);
      end
      check("key_ready_after_load", bus.key_ready, 1);
      tick();
      check("key_done_one_shot", bus.key_done, 0);
      check("key_ready_level",   bus.key_ready, 1);

      // Fill FIFO with data_ready low, then overflow
      bus.data_ready = 1'b0;
      drive_data(8'h11); data_q.push_back(8'h11);
      check("valid_after_push", bus.data_valid, 1);
      check("count_1", bus.fifo_count, 1);
      drive_data(8'h22); data_q.push_back(8'h22);
      drive_data(8'h33); data_q.push_back(8'h33);
      drive_data(8'h44); data_q.push_back(8'h44);
      check("count_4", bus.fifo_count, 4);
      check("no_overflow_yet", bus.overflow, 0);
      drive_data(8'h55);
      check("count_full", bus.fifo_count, 4);
      check("overflow_set", bus.overflow, 1);
      tick();
      check("head_stable", bus.data_word, 8'h11);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      check("overflow_cleared", bus.overflow, 0);

      // Full FIFO with a simultaneous pop accepts the push
      bus.data_ready = 1'b1;
      drive_data(8'h66); data_q.push_back(8'h66);
      check("full_pushpop_count", bus.fifo_count, 4);
      check("full_pushpop_ovf",   bus.overflow, 0);
      for (int i = 0; i < 10 && bus.data_valid; i++) tick();
      check("drained_valid", bus.data_valid, 0);
      check("drained_count", bus.fifo_count, 0);

      // Rekey flushes queued data
      bus.data_ready = 1'b0;
      drive_data(8'h77); data_q.push_back(8'h77);
      drive_data(8'h88); data_q.push_back(8'h88);
      drive_data(8'hAA); data_q.push_back(8'hAA);
      check("queued_3", bus.fifo_count, 3);
      data_q.delete();
      drive_key(8'h99, 4'd0, 1'b0);
      check("rekey_count", bus.fifo_count, 0);
      check("rekey_valid", bus.data_valid, 0);
      check("rekey_ready", bus.key_ready, 0);

      // Reset mid-load restarts the index
      for (int i = 1; i <= 7; i++) drive_key(8'(8'h90 + i), 4'(i), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_key_ready", bus.key_ready, 0);
      check("midrst_key_pulse", bus.key_pulse, 0);
      check("midrst_count",     bus.fifo_count, 0);
      check("midrst_drop",      bus.drop_nokey, 0);
      drive_data(8'hC3);
      check("midrst_nokey_drop", bus.drop_nokey, 1);
      drive_key(8'h5A, 4'd0, 1'b0);
      check("after_rst_ready", bus.key_ready, 0);
      tick();
      tick();

      check("key_q_empty",  key_q.size(),  0);
      check("data_q_empty", data_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_router.md
Name: stream_router

Overview:
- Parametrised successor of the single-byte reader router.
- Sits between the byte reader and the key storage / encryption blocks.
- Steers each pulsed input word either to the key path, with a slot index and completion tracking, or into a FIFO that feeds the encryption block over a valid/ready handshake.
- Adds key-state gating, rekey flush and overflow/drop error flags.

Parameters:
- DATA_W, 8, width of every data/key word.
- KEY_WORDS, 16, words per complete key (>=2).
- FIFO_DEPTH, 4, data FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_word  in  DATA_W  word from reader, sampled when in_pulse=1.
- in_is_key  in  1  qualifies in_word as key (1) or data (0), sampled with in_pulse.
- in_pulse  in  1  one-cycle strobe: input word valid.
- key_word  out  DATA_W  registered key word to key storage.
- key_idx  out  $clog2(KEY_WORDS)  slot index of key_word.
- key_pulse  out  1  one-cycle strobe: key_word/key_idx valid.
- key_done  out  1  one-cycle strobe with the last key word.
- key_ready  out  1  level: complete key loaded.
- data_word  out  DATA_W  FIFO head to encryption block.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  encryption block accepts head when data_valid=1.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky: data word dropped because FIFO full.
- drop_nokey  out  1  sticky: data word dropped because no complete key.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset (rst=1 at an edge):
  - all outputs 0 except key_word/data_word, which are don't-care but driven 0;
  - FIFO emptied, index counter 0, state NOKEY.
  - Reset mid-key-load or with a non-empty FIFO discards everything.
- States:
  - NOKEY: no key.
  - LOADING: partial key.
  - READY: key_ready=1.
- Key path, for in_pulse & in_is_key:
  - Next cycle: key_pulse=1, key_word=in_word, key_idx=counter. Latency is 1 cycle.
  - Counter increments.
  - NOKEY->LOADING on the first key word.
  - When counter==KEY_WORDS-1: key_done=1 with that key_pulse, counter wraps to 0, state->READY, key_ready rises in the same cycle as key_done.
- Rekey: a key word arriving in READY:
  - state->LOADING, key_ready drops the next cycle;
  - index restarts at 0;
  - the FIFO is flushed the same cycle: fifo_count=0 and data_valid=0 the next cycle, pending data discarded.
- Data path, for in_pulse & !in_is_key:
  - In READY: push if not full; data_valid is seen the cycle after the push (first-word-fall-through).
  - In NOKEY/LOADING: word discarded, drop_nokey set next cycle.
  - Full and no pop this cycle: word discarded, overflow set.
  - Full with a simultaneous pop (data_valid & data_ready): push accepted, count unchanged.
- Pop: data_valid & data_ready advances the head. Pointers wrap modulo FIFO_DEPTH.
- Occupancy: fifo_count = pushes - pops. Simultaneous push+pop leaves the count unchanged. It never exceeds FIFO_DEPTH.
- Flag priority:
  - err_clr has priority over a same-cycle set event; flag ends 0.
  - A set event occurring in the cycle after err_clr is recorded.
- in_pulse=0: in_word and in_is_key are ignored.
- Words after READY: data_word is stable while data_valid=1 and data_ready=0.

Test Plan:
1. Reset, then 16 key pulses 0x00..0x0F -> key_idx 0..15 one cycle after each; key_done and key_ready rise together with idx 15 (word 0x0F).
2. Data 0xA5 in NOKEY -> no push, fifo_count=0, drop_nokey=1; err_clr -> drop_nokey=0.
3. READY, data_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> fifo_count=4, overflow=1 after 0x55; then data_ready=1 -> 0x11..0x44 in order, data_valid=0 after.
4. FIFO full, push 0x66 with data_ready=1 in the same cycle -> 0x11 popped, 0x66 accepted, count stays 4, overflow unchanged.
5. READY with 3 words queued, key pulse 0x99 -> next cycle fifo_count=0, key_ready=0, key_pulse with idx 0 word 0x99.
6. Assert rst mid-load (after idx 7) -> key_ready=0 and state NOKEY; the next key word gets key_idx 0.
